// File: rtl/exec_unit.sv
// exec_unit: execute stage of a small 4-bit accumulator machine.
// It runs a FETCH -> EXEC cycle for each instruction and includes an
// ALU with carry/zero flags, a registered output port, two-byte jumps
// and a HALTED state that only reset can leave.
//
// Handshake: there is no valid/ready pair. fetch_en, pc_inc and pc_load
// are single-cycle enables that the fetch register and program counter
// act on at the next rising edge. pc_addr is valid only while pc_load=1.
module exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  instr,
    input  logic [3:0]  oprnd,
    input  logic [7:0]  prog_byte,
    input  logic [3:0]  data_in,
    output logic        fetch_en,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [11:0] pc_addr,
    output logic [3:0]  acc,
    output logic [3:0]  data_out,
    output logic        out_strobe,
    output logic        carry,
    output logic        zero,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_JNC  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_CMPI = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     st;
    logic       is_jump;
    logic       jump_taken;
    logic [4:0] sum5;
    logic [4:0] diff5;

    assign dbg_state = st;
    // The jump target is always {oprnd, prog_byte}; it is used only while pc_load=1.
    assign pc_addr   = {oprnd, prog_byte};

    // Adder and subtractor results. Bit 4 is the carry; in diff5 it is 1 when there is no borrow.
    always_comb begin
        sum5  = {1'b0, acc} + {1'b0, oprnd};
        diff5 = {1'b0, acc} + {1'b0, ~oprnd} + 5'd1;
    end

    // Jump decode. The flags are tested as they were held at the start of EXEC.
    always_comb begin
        is_jump    = 1'b0;
        jump_taken = 1'b0;
        case (instr)
            OP_JMP:  begin is_jump = 1'b1; jump_taken = 1'b1;   end
            OP_JC:   begin is_jump = 1'b1; jump_taken = carry;  end
            OP_JNC:  begin is_jump = 1'b1; jump_taken = ~carry; end
            OP_JZ:   begin is_jump = 1'b1; jump_taken = zero;   end
            OP_JNZ:  begin is_jump = 1'b1; jump_taken = ~zero;  end
            default: begin is_jump = 1'b0; jump_taken = 1'b0;   end
        endcase
    end

    // Combinational fetch and PC strobes. pc_inc and pc_load are never high together.
    always_comb begin
        fetch_en = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        case (st)
            FETCH: begin
                if (run) begin
                    fetch_en = 1'b1;
                    pc_inc   = 1'b1;
                end
            end
            EXEC: begin
                if (is_jump) begin
                    if (jump_taken) pc_load = 1'b1;
                    else            pc_inc  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM, architectural registers and the registered output pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= FETCH;
            acc        <= 4'h0;
            data_out   <= 4'h0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            out_strobe <= 1'b0;
            halted     <= 1'b0;
        end else begin
            out_strobe <= 1'b0;
            case (st)
                FETCH: begin
                    if (run) st <= EXEC;
                end
                EXEC: begin
                    st <= FETCH;
                    case (instr)
                        OP_NOP: ;
                        OP_LIT: begin
                            acc  <= oprnd;
                            zero <= (oprnd == 4'h0);
                        end
                        OP_ADDI: begin
                            acc   <= sum5[3:0];
                            carry <= sum5[4];
                            zero  <= (sum5[3:0] == 4'h0);
                        end
                        OP_SUBI: begin
                            acc   <= diff5[3:0];
                            carry <= diff5[4];
                            zero  <= (diff5[3:0] == 4'h0);
                        end
                        OP_ANDI: begin
                            acc  <= acc & oprnd;
                            zero <= ((acc & oprnd) == 4'h0);
                        end
                        OP_ORI: begin
                            acc  <= acc | oprnd;
                            zero <= ((acc | oprnd) == 4'h0);
                        end
                        OP_XORI: begin
                            acc  <= acc ^ oprnd;
                            zero <= ((acc ^ oprnd) == 4'h0);
                        end
                        OP_IN: begin
                            acc  <= data_in;
                            zero <= (data_in == 4'h0);
                        end
                        OP_OUT: begin
                            data_out   <= acc;
                            out_strobe <= 1'b1;
                        end
                        OP_CMPI: begin
                            carry <= diff5[4];
                            zero  <= (diff5[3:0] == 4'h0);
                        end
                        OP_HALT: begin
                            st     <= HALTED;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALTED: st <= HALTED;
                default: st <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit. It applies a table of directed instruction vectors,
// then hand-written sequences for the stall, OUT, HALT and reset cases,
// then random instructions checked against a reference model.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [7:0]  prog_byte;
    logic [3:0]  data_in;
    logic        fetch_en;
    logic        pc_inc;
    logic        pc_load;
    logic [11:0] pc_addr;
    logic [3:0]  acc;
    logic [3:0]  data_out;
    logic        out_strobe;
    logic        carry;
    logic        zero;
    logic        halted;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    exec_unit dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .oprnd(oprnd),
        .prog_byte(prog_byte), .data_in(data_in), .fetch_en(fetch_en),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_addr(pc_addr), .acc(acc),
        .data_out(data_out), .out_strobe(out_strobe), .carry(carry),
        .zero(zero), .halted(halted), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  opr;
        logic [7:0]  pb;
        logic [3:0]  din;
        logic        e_load;
        logic        e_inc;
        logic [3:0]  e_acc;
        logic        e_c;
        logic        e_z;
        logic [3:0]  e_dout;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    int m_acc, m_c, m_z, m_dout;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH. Returns at the negedge after the EXEC cycle.
    task automatic do_instr(input vec_t v);
        run = 1'b1; instr = v.op; oprnd = v.opr; prog_byte = v.pb; data_in = v.din;
        #1;
        chk("fetch_en_f", {15'd0, fetch_en}, 16'd1);
        chk("pc_inc_f", {15'd0, pc_inc}, 16'd1);
        chk("pc_load_f", {15'd0, pc_load}, 16'd0);
        @(negedge clk);
        chk("fetch_en_e", {15'd0, fetch_en}, 16'd0);
        chk("pc_load_e", {15'd0, pc_load}, {15'd0, v.e_load});
        chk("pc_inc_e", {15'd0, pc_inc}, {15'd0, v.e_inc});
        if (v.e_load) chk("pc_addr", {4'd0, pc_addr}, {4'd0, v.opr, v.pb});
        @(negedge clk);
        chk("acc", {12'd0, acc}, {12'd0, v.e_acc});
        chk("carry", {15'd0, carry}, {15'd0, v.e_c});
        chk("zero", {15'd0, zero}, {15'd0, v.e_z});
        chk("data_out", {12'd0, data_out}, {12'd0, v.e_dout});
        chk("out_strobe", {15'd0, out_strobe}, {15'd0, (v.op == 4'h8)});
    endtask

    // Reference model: derive the expected outcome of one instruction from the ISA rules.
    task automatic model(input logic [3:0] op, input logic [3:0] opr, input logic [7:0] pb,
                         input logic [3:0] din, output vec_t v);
        int taken;
        int r;
        v.op = op; v.opr = opr; v.pb = pb; v.din = din;
        taken = 0;
        case (op)
            4'h9: taken = 1;
            4'hA: taken = m_c;
            4'hB: taken = !m_c;
            4'hC: taken = m_z;
            4'hD: taken = !m_z;
            default: taken = 0;
        endcase
        v.e_load = (op >= 4'h9 && op <= 4'hD) && taken != 0;
        v.e_inc  = (op >= 4'h9 && op <= 4'hD) && taken == 0;
        case (op)
            4'h1: begin m_acc = opr; m_z = (m_acc == 0); end
            4'h2: begin r = m_acc + opr; m_c = (r > 15); m_acc = r % 16; m_z = (m_acc == 0); end
            4'h3: begin m_c = (m_acc >= opr); m_acc = (m_acc - opr + 16) % 16; m_z = (m_acc == 0); end
            4'h4: begin m_acc = m_acc & opr; m_z = (m_acc == 0); end
            4'h5: begin m_acc = m_acc | opr; m_z = (m_acc == 0); end
            4'h6: begin m_acc = m_acc ^ opr; m_z = (m_acc == 0); end
            4'h7: begin m_acc = din; m_z = (m_acc == 0); end
            4'h8: m_dout = m_acc;
            4'hE: begin m_c = (m_acc >= opr); m_z = (m_acc == opr); end
            default: ;
        endcase
        v.e_acc = m_acc[3:0]; v.e_c = m_c[0]; v.e_z = m_z[0]; v.e_dout = m_dout[3:0];
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_acc = 0; m_c = 0; m_z = 0; m_dout = 0;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [3:0] opr, input logic [7:0] pb,
                                input logic [3:0] din, input logic ld, input logic inc,
                                input logic [3:0] a, input logic c, input logic z, input logic [3:0] d);
        vec_t v;
        v.op = op; v.opr = opr; v.pb = pb; v.din = din; v.e_load = ld; v.e_inc = inc;
        v.e_acc = a; v.e_c = c; v.e_z = z; v.e_dout = d;
        return v;
    endfunction

    initial begin
        vec_t v;
        reset = 1'b1; run = 1'b0; instr = 4'h0; oprnd = 4'h0; prog_byte = 8'h00; data_in = 4'h0;

        // directed table: op opr pb din | load inc acc c z dout
        vecs.push_back(mk(4'h1, 4'h5, 8'h00, 4'h0, 0, 0, 4'h5, 0, 0, 4'h0)); // LIT 5
        vecs.push_back(mk(4'h2, 4'hC, 8'h00, 4'h0, 0, 0, 4'h1, 1, 0, 4'h0)); // ADDI C
        vecs.push_back(mk(4'h1, 4'h5, 8'h00, 4'h0, 0, 0, 4'h5, 1, 0, 4'h0)); // LIT 5
        vecs.push_back(mk(4'h3, 4'h5, 8'h00, 4'h0, 0, 0, 4'h0, 1, 1, 4'h0)); // SUBI 5
        vecs.push_back(mk(4'hE, 4'h6, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0)); // CMPI 6
        vecs.push_back(mk(4'h1, 4'h0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 1, 4'h0)); // LIT 0
        vecs.push_back(mk(4'hC, 4'h2, 8'h34, 4'h0, 1, 0, 4'h0, 0, 1, 4'h0)); // JZ taken
        vecs.push_back(mk(4'hA, 4'h1, 8'h11, 4'h0, 0, 1, 4'h0, 0, 1, 4'h0)); // JC not taken
        vecs.push_back(mk(4'hB, 4'h7, 8'hEE, 4'h0, 1, 0, 4'h0, 0, 1, 4'h0)); // JNC taken
        vecs.push_back(mk(4'h1, 4'h1, 8'h00, 4'h0, 0, 0, 4'h1, 0, 0, 4'h0)); // LIT 1
        vecs.push_back(mk(4'hC, 4'h2, 8'h34, 4'h0, 0, 1, 4'h1, 0, 0, 4'h0)); // JZ not taken
        vecs.push_back(mk(4'h1, 4'hA, 8'h00, 4'h0, 0, 0, 4'hA, 0, 0, 4'h0)); // LIT A
        vecs.push_back(mk(4'h4, 4'h6, 8'h00, 4'h0, 0, 0, 4'h2, 0, 0, 4'h0)); // ANDI 6
        vecs.push_back(mk(4'h5, 4'h5, 8'h00, 4'h0, 0, 0, 4'h7, 0, 0, 4'h0)); // ORI 5
        vecs.push_back(mk(4'h6, 4'h7, 8'h00, 4'h0, 0, 0, 4'h0, 0, 1, 4'h0)); // XORI 7
        vecs.push_back(mk(4'hD, 4'h3, 8'h21, 4'h0, 0, 1, 4'h0, 0, 1, 4'h0)); // JNZ not taken
        vecs.push_back(mk(4'h7, 4'h0, 8'h00, 4'h9, 0, 0, 4'h9, 0, 0, 4'h0)); // IN 9
        vecs.push_back(mk(4'hD, 4'hF, 8'hFF, 4'h0, 1, 0, 4'h9, 0, 0, 4'h0)); // JNZ taken
        vecs.push_back(mk(4'h8, 4'h0, 8'h00, 4'h0, 0, 0, 4'h9, 0, 0, 4'h9)); // OUT
        vecs.push_back(mk(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 4'h9, 0, 0, 4'h9)); // NOP: strobe drops
        vecs.push_back(mk(4'h9, 4'h0, 8'h00, 4'h0, 1, 0, 4'h9, 0, 0, 4'h9)); // JMP 0x000

        apply_reset();
        chk("rst_state", {14'd0, dbg_state}, 16'd0);
        chk("rst_acc", {12'd0, acc}, 16'd0);
        chk("rst_flags", {13'd0, carry, zero, halted}, 16'd0);
        chk("rst_out", {11'd0, out_strobe, data_out}, 16'd0);

        foreach (vecs[i]) do_instr(vecs[i]);

        // stall: run=0 for 5 cycles in FETCH with an instruction that would change acc
        run = 1'b0; instr = 4'h1; oprnd = 4'h3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_strobes", {13'd0, fetch_en, pc_inc, pc_load}, 16'd0);
            chk("stall_state", {14'd0, dbg_state}, 16'd0);
            chk("stall_acc", {12'd0, acc}, 16'h9);
            @(negedge clk);
        end

        // HALT, then 10 cycles with run=1
        apply_reset();
        model(4'h1, 4'h6, 8'h00, 4'h0, v); do_instr(v);
        v = mk(4'hF, 4'h0, 8'h00, 4'h0, 0, 0, 4'h6, 0, 0, 4'h0); do_instr(v);
        chk("halted", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 10; i++) begin
            run = 1'b1; instr = 4'h1; oprnd = 4'h2;
            #1;
            chk("halt_strobes", {13'd0, fetch_en, pc_inc, pc_load}, 16'd0);
            chk("halt_hold", {11'd0, halted, acc}, 16'h16);
            @(negedge clk);
        end
        apply_reset();
        chk("unhalt", {13'd0, halted, dbg_state}, 16'd0);

        // reset during EXEC of ADDI 4 with acc=3
        model(4'h1, 4'h3, 8'h00, 4'h0, v); do_instr(v);
        run = 1'b1; instr = 4'h2; oprnd = 4'h4;
        @(negedge clk);
        chk("mid_exec", {14'd0, dbg_state}, 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_acc = 0; m_c = 0; m_z = 0; m_dout = 0;
        chk("rst_exec_acc", {12'd0, acc}, 16'd0);
        chk("rst_exec_flags", {14'd0, carry, zero}, 16'd0);
        chk("rst_exec_state", {14'd0, dbg_state}, 16'd0);

        // random instructions against the model (no HALT)
        for (int i = 0; i < 300; i++) begin
            model($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 255),
                  $urandom_range(0, 15), v);
            do_instr(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameters: none; widths fixed as listed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 run  input  1  permits leaving FETCH state; 0 = stall in FETCH.
REQ-005 instr  input  4  opcode from fetch register.
REQ-006 oprnd  input  4  operand from fetch register; also jump address bits [11:8].
REQ-007 prog_byte  input  8  current program ROM output (byte at PC); jump address bits [7:0].
REQ-008 data_in  input  4  external input port read by IN.
REQ-009 fetch_en  output  1  enable to fetch register; combinational.
REQ-010 pc_inc  output  1  enable to program counter increment; combinational.
REQ-011 pc_load  output  1  program counter load strobe; combinational.
REQ-012 pc_addr  output  12  always {oprnd, prog_byte}; meaningful only while pc_load=1.
REQ-013 acc  output  4  accumulator, registered.
REQ-014 data_out  output  4  output port, registered.
REQ-015 out_strobe  output  1  registered one-cycle pulse, data_out updated.
REQ-016 carry, zero  output  1 each  registered flags C and Z.
REQ-017 halted  output  1  high while in HALTED state.

Function
REQ-018 States: FETCH, EXEC, HALTED; one executed instruction per FETCH->EXEC pair.
REQ-019 FETCH, run=1: fetch_en=1, pc_inc=1, pc_load=0; next state EXEC.
REQ-020 FETCH, run=0: fetch_en=pc_inc=pc_load=0; remain FETCH; no register changes.
REQ-021 EXEC: fetch_en=0; ops below take effect at the rising edge ending EXEC; next state FETCH, except HALT -> HALTED; run ignored in EXEC.
REQ-022 Opcodes: 0 NOP; 1 LIT acc<=oprnd; 2 ADDI; 3 SUBI; 4 ANDI; 5 ORI; 6 XORI; 7 IN acc<=data_in; 8 OUT; 9 JMP; A JC; B JNC; C JZ; D JNZ; E CMPI; F HALT.
REQ-023 ADDI: 5-bit {C,acc} <= acc + oprnd; wrap modulo 16, C = bit 4.
REQ-024 SUBI: 5-bit sum acc + ~oprnd + 1; acc <= low 4 bits; C <= bit 4 (1 = no borrow).
REQ-025 CMPI: as SUBI but acc unchanged; only C and Z updated.
REQ-026 Z <= (new result == 0) for LIT, ADDI, SUBI, ANDI, ORI, XORI, IN, CMPI; all other ops leave Z.
REQ-027 C changes only on ADDI, SUBI, CMPI.
REQ-028 OUT: data_out <= acc; out_strobe=1 for exactly the cycle after EXEC; 0 otherwise.
REQ-029 Jumps are two-byte: byte 1 = {opcode, addr[11:8]}, byte 2 = addr[7:0], present on prog_byte during EXEC.
REQ-030 Jump taken (JMP always; JC C=1; JNC C=0; JZ Z=1; JNZ Z=0): in EXEC pc_load=1, pc_inc=0.
REQ-031 Jump not taken: in EXEC pc_inc=1, pc_load=0 (skips byte 2).
REQ-032 Non-jump ops in EXEC: pc_inc=0, pc_load=0; pc_load and pc_inc never both 1.
REQ-033 HALTED: all strobes 0, halted=1, registers frozen; exit only by reset.
REQ-034 Flags are tested as held at start of EXEC (value from prior instructions).

Reset
REQ-035 reset=1 at a rising edge: state<=FETCH; acc, data_out, carry, zero, out_strobe, halted <= 0.
REQ-036 Reset overrides any op in progress, including mid-EXEC and HALTED; that op has no effect.
REQ-037 Combinational outputs during reset cycle follow current state; surrounding stages reset concurrently.

Verification
REQ-038 Reset, run=1, LIT 5 then ADDI 0xC -> after first EXEC acc=5, Z=0; after second acc=1, C=1, Z=0.
REQ-039 acc=5, SUBI 5 -> acc=0, C=1, Z=1; then CMPI 6 -> acc=0, C=0, Z=0.
REQ-040 Z=1, JZ oprnd=2, prog_byte=0x34 -> EXEC cycle pc_load=1, pc_addr=0x234, pc_inc=0; same with Z=0 -> pc_inc=1, pc_load=0.
REQ-041 acc=9, OUT -> data_out=9, out_strobe high exactly one cycle; run=0 in FETCH for 5 cycles -> all strobes 0, state held.
REQ-042 HALT -> halted=1, fetch_en=0 for 10 cycles despite run=1; reset -> halted=0, state FETCH.
REQ-043 acc=3, reset asserted during EXEC of ADDI 4 -> acc=0, C=0, Z=0, next cycle in FETCH.
